buzz_sched: RTL and testbench

Three-channel beep-pattern scheduler for the board buzzer. Requesters such as key click, warning and alarm each ask for a pattern: N beeps of programmable on/off length and tone period. The block arbitrates by fixed priority, with preemption, and times the on/off phases on a millisecond tick. It drives the buzzer pin through an internal square-wave tone generator.

---
 rtl/buzz_pkg.sv | 25 ++
 rtl/buzz_tone.sv | 42 ++++
 rtl/buzz_sched.sv | 197 +++++++++++++++++++
 tb/tb_buzz_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzz_pkg.sv
// Shared types and field widths for the three-channel buzzer pattern scheduler.
package buzz_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned MS_W  = 10;
  localparam int unsigned PER_W = 16;
  localparam int unsigned OWN_W = 2;

  localparam logic [OWN_W-1:0] OWNER_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  // One channel's requested beep pattern.
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [MS_W-1:0]  on;
    logic [MS_W-1:0]  off;
    logic [PER_W-1:0] per;
  } pat_t;

endpackage

// File: rtl/buzz_tone.sv
// Square-wave tone generator: period counter with 50% duty, low half first.
module buzz_tone
  import buzz_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [PER_W-1:0] per,
  output logic             buz
);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             buz_q, buz_d;
  logic             audible;

  // Periods below 2 cannot form a square wave, so the beep is silent.
  always_comb begin
    cnt_d   = '0;
    buz_d   = 1'b0;
    audible = (per >= PER_W'(2));
    if (en && !restart) begin
      if (audible && (cnt_q < per - PER_W'(1))) begin
        cnt_d = cnt_q + PER_W'(1);
      end
      buz_d = audible && (cnt_d >= (per >> 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      buz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      buz_q <= buz_d;
    end
  end

  assign buz = buz_q;

endmodule

// File: rtl/buzz_sched.sv
// Fixed-priority, preemptive beep-pattern scheduler with ms phase timing.
module buzz_sched
  import buzz_pkg::*;
#(
  parameter int unsigned MS_DIV = 50000,
  parameter int unsigned NCH    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*CNT_W-1:0] req_cnt,
  input  logic [NCH*MS_W-1:0]  req_on,
  input  logic [NCH*MS_W-1:0]  req_off,
  input  logic [NCH*PER_W-1:0] req_per,
  output logic [NCH-1:0]       ack,
  output logic [NCH-1:0]       done,
  output logic [NCH-1:0]       abrt,
  output logic                 busy,
  output logic [OWN_W-1:0]     owner,
  output logic                 buz
);

  localparam int unsigned     PRE_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);

  state_e           state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic             busy_q, busy_d;
  logic [NCH-1:0]   ack_q, ack_d;
  logic [NCH-1:0]   done_q, done_d;
  logic [NCH-1:0]   abrt_q, abrt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [MS_W-1:0]  on_q, on_d;
  logic [MS_W-1:0]  off_q, off_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [MS_W-1:0]  ms_q, ms_d;

  logic             win_vld;
  logic [OWN_W-1:0] win;
  pat_t             sel;
  logic             tick;
  logic             expire;
  logic             tone_en;
  logic             tone_restart;

  // Highest-index request that may take the buzzer now (any when idle, higher than owner otherwise).
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    sel     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (req[i] && (state_q == ST_IDLE || OWN_W'(i) > owner_q)) begin
        win_vld = 1'b1;
        win     = OWN_W'(i);
        sel.cnt = req_cnt[i*CNT_W +: CNT_W];
        sel.on  = req_on[i*MS_W +: MS_W];
        sel.off = req_off[i*MS_W +: MS_W];
        sel.per = req_per[i*PER_W +: PER_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    ack_d        = '0;
    done_d       = '0;
    abrt_d       = '0;
    rem_d        = rem_q;
    on_d         = on_q;
    off_d        = off_q;
    per_d        = per_q;
    pre_d        = pre_q;
    ms_d         = ms_q;
    tone_restart = 1'b0;
    tick         = (pre_q == PRE_LAST);
    expire       = tick && (ms_q == MS_W'(1));

    // Free-running ms prescaler inside an active phase.
    if (state_q != ST_IDLE) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      ms_d  = tick ? ms_q - MS_W'(1) : ms_q;
    end

    if (win_vld) begin
      // A grant (fresh or preempting) takes priority over any phase expiry.
      if (state_q != ST_IDLE) begin
        abrt_d[owner_q] = 1'b1;
      end
      ack_d[win] = 1'b1;
      rem_d      = sel.cnt;
      on_d       = sel.on;
      off_d      = sel.off;
      per_d      = sel.per;
      pre_d      = '0;
      ms_d       = sel.on;
      if (sel.cnt == '0 || sel.on == '0) begin
        state_d     = ST_IDLE;
        done_d[win] = 1'b1;
        owner_d     = OWNER_NONE;
        busy_d      = 1'b0;
        rem_d       = '0;
        ms_d        = '0;
      end else begin
        state_d      = ST_ON;
        owner_d      = win;
        busy_d       = 1'b1;
        tone_restart = 1'b1;
      end
    end else begin
      case (state_q)
        ST_ON: begin
          if (expire) begin
            pre_d = '0;
            if (rem_q == CNT_W'(1)) begin
              state_d         = ST_IDLE;
              done_d[owner_q] = 1'b1;
              owner_d         = OWNER_NONE;
              busy_d          = 1'b0;
              rem_d           = '0;
              ms_d            = '0;
            end else begin
              rem_d = rem_q - CNT_W'(1);
              if (off_q != '0) begin
                state_d = ST_OFF;
                ms_d    = off_q;
              end else begin
                state_d      = ST_ON;
                ms_d         = on_q;
                tone_restart = 1'b1;
              end
            end
          end
        end
        ST_OFF: begin
          if (expire) begin
            state_d      = ST_ON;
            pre_d        = '0;
            ms_d         = on_q;
            tone_restart = 1'b1;
          end
        end
        default: ;
      endcase
    end

    tone_en = (state_d == ST_ON);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_NONE;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      abrt_q  <= '0;
      rem_q   <= '0;
      on_q    <= '0;
      off_q   <= '0;
      per_q   <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      rem_q   <= rem_d;
      on_q    <= on_d;
      off_q   <= off_d;
      per_q   <= per_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
    end
  end

  buzz_tone u_tone (
    .clk     (clk),
    .rst     (rst),
    .en      (tone_en),
    .restart (tone_restart),
    .per     (per_q),
    .buz     (buz)
  );

  assign ack   = ack_q;
  assign done  = done_q;
  assign abrt  = abrt_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_buzz_sched.sv
// Bench for buzz_sched: directed pattern table, corner sequences, and random traffic vs a cycle-count model.
module tb_buzz_sched;

  localparam int MSD = 10;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [11:0] req_cnt;
  logic [29:0] req_on;
  logic [29:0] req_off;
  logic [47:0] req_per;
  logic [2:0]  ack, done, abrt;
  logic        busy;
  logic [1:0]  owner;
  logic        buz;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;

  // Reference model: phase lengths counted directly in clock cycles.
  int m_state;  // 0 idle, 1 beep on, 2 gap off
  int m_owner, m_rem, m_on, m_off, m_per, m_left, m_el;
  logic [2:0] e_ack, e_done, e_abrt;

  buzz_sched #(.MS_DIV(MSD), .NCH(3)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cnt(req_cnt), .req_on(req_on),
    .req_off(req_off), .req_per(req_per), .ack(ack), .done(done), .abrt(abrt),
    .busy(busy), .owner(owner), .buz(buz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, ncyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_owner = 3; m_rem = 0; m_left = 0; m_el = 0;
    m_on = 0; m_off = 0; m_per = 0;
    e_ack = '0; e_done = '0; e_abrt = '0;
  endtask

  task automatic model_step();
    int w, c, o, f, p;
    e_ack = '0; e_done = '0; e_abrt = '0;
    if (rst) begin
      model_reset();
      return;
    end
    w = -1;
    for (int i = 0; i < 3; i++)
      if (req[i] && (m_state == 0 || i > m_owner)) w = i;
    if (w >= 0) begin
      c = int'(req_cnt[w*4 +: 4]);
      o = int'(req_on[w*10 +: 10]);
      f = int'(req_off[w*10 +: 10]);
      p = int'(req_per[w*16 +: 16]);
      if (m_state != 0) e_abrt[m_owner] = 1'b1;
      e_ack[w] = 1'b1;
      if (c == 0 || o == 0) begin
        m_state = 0; m_owner = 3; e_done[w] = 1'b1;
      end else begin
        m_state = 1; m_owner = w; m_rem = c; m_on = o; m_off = f; m_per = p;
        m_left = o * MSD; m_el = 0;
      end
    end else if (m_state != 0) begin
      m_left--; m_el++;
      if (m_left == 0) begin
        m_el = 0;
        if (m_state == 1) begin
          m_rem--;
          if (m_rem == 0) begin
            e_done[m_owner] = 1'b1; m_state = 0; m_owner = 3;
          end else if (m_off == 0) begin
            m_left = m_on * MSD;
          end else begin
            m_state = 2; m_left = m_off * MSD;
          end
        end else begin
          m_state = 1; m_left = m_on * MSD;
        end
      end
    end
  endtask

  function automatic logic exp_buz();
    return (m_state == 1) && (m_per >= 2) && ((m_el % m_per) >= (m_per / 2));
  endfunction

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    ncyc++;
    chk("outputs{ack,done,abrt,busy,owner,buz}",
        32'({ack, done, abrt, busy, owner, buz}),
        32'({e_ack, e_done, e_abrt, (m_state != 0), 2'(m_owner), exp_buz()}));
  endtask

  task automatic set_ch(input int ch, input int c, input int o, input int f, input int p);
    req_cnt[ch*4 +: 4]   = 4'(c);
    req_on[ch*10 +: 10]  = 10'(o);
    req_off[ch*10 +: 10] = 10'(f);
    req_per[ch*16 +: 16] = 16'(p);
  endtask

  task automatic wait_ack(input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (ack == 3'b000 && n < budget);
    if (ack == 3'b000) begin
      checks++; failures++;
      $display("FAIL ack_timeout: no ack within %0d cycles", budget);
    end
  endtask

  // Called on the ack sample; follows the pattern to its done pulse.
  task automatic run_to_done(input int budget, output int bcnt, output int rises, output logic [2:0] d);
    logic prev;
    int n = 0;
    bcnt = int'(busy); rises = 0; prev = buz; d = done;
    while (d == 3'b000 && n < budget) begin
      cycle();
      n++;
      bcnt += int'(busy);
      if (buz && !prev) rises++;
      prev = buz;
      d = done;
    end
    if (d == 3'b000) begin
      checks++; failures++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  typedef struct {
    int ch, cnt, on, off, per;
    int exp_busy;   // cycles with busy=1
    int exp_rises;  // buz rising edges during the pattern
  } vec_t;

  initial begin
    vec_t vecs[8];
    int bcnt, rises;
    logic [2:0] d;

    vecs[0] = '{0, 1, 2, 0, 8, 20, 2};
    vecs[1] = '{1, 3, 1, 1, 4, 50, 6};
    vecs[2] = '{2, 0, 5, 1, 8, 0, 0};
    vecs[3] = '{0, 2, 1, 0, 1, 20, 0};
    vecs[4] = '{2, 2, 1, 0, 6, 20, 4};
    vecs[5] = '{1, 1, 3, 7, 5, 30, 6};
    vecs[6] = '{1, 4, 0, 2, 4, 0, 0};
    vecs[7] = '{1, 2, 1, 2, 3, 40, 6};

    rst = 1'b1; req = '0; req_cnt = '0; req_on = '0; req_off = '0; req_per = '0;
    model_reset();
    repeat (3) cycle();
    chk("reset_state", 32'({ack, done, abrt, busy, owner, buz}), 32'({9'b0, 1'b0, 2'b11, 1'b0}));
    rst = 1'b0;
    repeat (2) cycle();

    // Directed patterns from the table.
    for (int v = 0; v < 8; v++) begin
      set_ch(vecs[v].ch, vecs[v].cnt, vecs[v].on, vecs[v].off, vecs[v].per);
      req = 3'(1 << vecs[v].ch);
      wait_ack(5);
      chk($sformatf("vec%0d_ack", v), 32'(ack), 32'(1 << vecs[v].ch));
      req = '0;
      run_to_done(2000, bcnt, rises, d);
      chk($sformatf("vec%0d_done", v), 32'(d), 32'(1 << vecs[v].ch));
      chk($sformatf("vec%0d_busy_cycles", v), 32'(bcnt), 32'(vecs[v].exp_busy));
      chk($sformatf("vec%0d_buz_rises", v), 32'(rises), 32'(vecs[v].exp_rises));
      chk($sformatf("vec%0d_idle_owner", v), 32'({busy, owner}), 32'(3'b011));
      repeat (2) cycle();
    end

    // Simultaneous requests are served strictly by priority.
    set_ch(2, 1, 1, 0, 4); set_ch(1, 1, 1, 0, 4); set_ch(0, 1, 1, 0, 4);
    req = 3'b111;
    cycle();
    chk("tie_ack2", 32'(ack), 32'(3'b100));
    req[2] = 1'b0;
    run_to_done(500, bcnt, rises, d);
    chk("tie_done2", 32'(d), 32'(3'b100));
    cycle();
    chk("tie_ack1", 32'(ack), 32'(3'b010));
    req[1] = 1'b0;
    run_to_done(500, bcnt, rises, d);
    chk("tie_done1", 32'(d), 32'(3'b010));
    cycle();
    chk("tie_ack0", 32'(ack), 32'(3'b001));
    req[0] = 1'b0;
    run_to_done(500, bcnt, rises, d);
    chk("tie_done0", 32'(d), 32'(3'b001));
    repeat (2) cycle();

    // Preemption during the second gap of a five-beep pattern.
    set_ch(0, 5, 1, 1, 4);
    req = 3'b001;
    wait_ack(5);
    req = '0;
    repeat (33) cycle();
    chk("pre_before", 32'({busy, owner, buz}), 32'({1'b1, 2'b00, 1'b0}));
    set_ch(2, 1, 1, 0, 6);
    req[2] = 1'b1;
    cycle();
    chk("pre_abrt_ack", 32'({abrt, ack, done}), 32'({3'b001, 3'b100, 3'b000}));
    chk("pre_owner", 32'(owner), 32'(2));
    req = '0;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk($sformatf("pre_buz_k%0d", k), 32'(buz), 32'(k >= 3));
    end
    run_to_done(500, bcnt, rises, d);
    chk("pre_done2", 32'(d), 32'(3'b100));
    repeat (2) cycle();

    // Asynchronous reset in the middle of a beep, with the request held.
    set_ch(1, 2, 2, 0, 4);
    req = 3'b010;
    wait_ack(5);
    repeat (6) cycle();
    chk("rst_pre_buz", 32'({buz, busy}), 32'(2'b11));
    #2 rst = 1'b1;
    #1 chk("rst_async", 32'({ack, done, abrt, busy, owner, buz}), 32'({9'b0, 1'b0, 2'b11, 1'b0}));
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk("rst_regrant", 32'({ack, owner}), 32'({3'b010, 2'b01}));
    req = '0;
    run_to_done(500, bcnt, rises, d);
    chk("rst_done", 32'(d), 32'(3'b010));
    chk("rst_busy_cycles", 32'(bcnt), 32'(40));

    // Random traffic; fields change freely and are only sampled at grant.
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if ($urandom_range(0, 3) == 0)
          set_ch(ch, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 9)));
        if (req[ch] && ack[ch] && $urandom_range(0, 3) != 0) req[ch] = 1'b0;
        else if (!req[ch] && $urandom_range(0, 39) == 0) req[ch] = 1'b1;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
